// File: rtl/control_unit.sv
// Moore FSM sequencing the multicycle CPU datapath: decodes OPCODE/FUNCT and drives every select/load.
// Outputs are registered from the next-state decode, so they change together with state_o.
module control_unit #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Overflow,
    input  logic       Zero,
    output logic       PCwrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       RegDest,
    output logic       AluSrcA,
    output logic       EPCWrite,
    output logic       IorD,
    output logic [3:0] AluSrcB,
    output logic [3:0] PCSource,
    output logic [3:0] WriteSrc,
    output logic [3:0] Exception,
    output logic [2:0] ShiftControl,
    output logic [2:0] ALUControl,
    output logic [4:0] state_o
);
    typedef enum logic [4:0] {
        S_FETCH = 5'd0, S_DECODE = 5'd1, S_EXEC_R = 5'd2, S_WB_R = 5'd3, S_EXEC_I = 5'd4,
        S_WB_I = 5'd5, S_JR = 5'd6, S_SH_LD = 5'd7, S_SH_OP = 5'd8, S_SH_WB = 5'd9,
        S_MEM_ADDR = 5'd10, S_MEM_RD = 5'd11, S_MEM_WB = 5'd12, S_MEM_WR = 5'd13,
        S_BRANCH = 5'd14, S_JUMP = 5'd15, S_EXC = 5'd16, S_EXC_RD = 5'd17, S_EXC_JMP = 5'd18
    } state_t;

    typedef struct packed {
        logic       pcw, memw, memr, irw, regw, memtoreg, regdst, srca, epcw, iord;
        logic       pc_cond, bne;
        logic [3:0] srcb, pcsrc, wsrc, exc;
        logic [2:0] sh, alu;
    } ctl_t;

    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_JR = 6'h08;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02;
    localparam logic [3:0] EXC_SEL_OPC = 4'd1, EXC_SEL_OVF = 4'd2;
    localparam logic [2:0] ALU_PASSA = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011;
    localparam logic [2:0] LAST_WAIT = 3'(MEM_WAIT);

    state_t     r_state, w_nstate;
    logic [2:0] r_wait, w_nwait;
    logic [3:0] r_exc, w_nexc;
    logic       r_run;
    ctl_t       r_ctl, w_ctl;

    always_comb begin
        w_nstate = S_FETCH;
        w_nwait  = '0;
        w_nexc   = r_exc;
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    if (r_wait == LAST_WAIT) w_nstate = S_DECODE;
                    else begin
                        w_nstate = S_FETCH;
                        w_nwait  = r_wait + 3'd1;
                    end
                end
                S_DECODE: begin
                    case (OPCODE)
                        OP_R: begin
                            case (FUNCT)
                                FN_ADD, FN_SUB, FN_AND: w_nstate = S_EXEC_R;
                                FN_JR:                  w_nstate = S_JR;
                                FN_SLL, FN_SRL:         w_nstate = S_SH_LD;
                                default: begin
                                    w_nstate = S_EXC;
                                    w_nexc   = EXC_SEL_OPC;
                                end
                            endcase
                        end
                        OP_ADDI:        w_nstate = S_EXEC_I;
                        OP_LW, OP_SW:   w_nstate = S_MEM_ADDR;
                        OP_BEQ, OP_BNE: w_nstate = S_BRANCH;
                        OP_J:           w_nstate = S_JUMP;
                        default: begin
                            w_nstate = S_EXC;
                            w_nexc   = EXC_SEL_OPC;
                        end
                    endcase
                end
                // 'and' cannot overflow, so only add/sub trap here
                S_EXEC_R, S_EXEC_I: begin
                    if (Overflow && !(r_state == S_EXEC_R && FUNCT == FN_AND)) begin
                        w_nstate = S_EXC;
                        w_nexc   = EXC_SEL_OVF;
                    end else begin
                        w_nstate = (r_state == S_EXEC_R) ? S_WB_R : S_WB_I;
                    end
                end
                S_SH_LD:    w_nstate = S_SH_OP;
                S_SH_OP:    w_nstate = S_SH_WB;
                S_MEM_ADDR: w_nstate = (OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_EXC:      w_nstate = S_EXC_RD;
                S_MEM_RD, S_EXC_RD: begin
                    if (r_wait == LAST_WAIT) begin
                        w_nstate = (r_state == S_MEM_RD) ? S_MEM_WB : S_EXC_JMP;
                    end else begin
                        w_nstate = r_state;
                        w_nwait  = r_wait + 3'd1;
                    end
                end
                default: w_nstate = S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_ctl = '0;
        case (w_nstate)
            S_FETCH: begin
                w_ctl.memr = 1'b1;
                w_ctl.srcb = 4'd1;
                w_ctl.alu  = ALU_ADD;
                w_ctl.irw  = (w_nwait == LAST_WAIT);
                w_ctl.pcw  = (w_nwait == LAST_WAIT);
            end
            S_DECODE: begin
                w_ctl.srcb = 4'd3;
                w_ctl.alu  = ALU_ADD;
            end
            S_EXEC_R: begin
                w_ctl.srca = 1'b1;
                w_ctl.alu  = (FUNCT == FN_SUB) ? ALU_SUB : (FUNCT == FN_AND) ? ALU_AND : ALU_ADD;
            end
            S_WB_R, S_SH_WB: begin
                w_ctl.regw   = 1'b1;
                w_ctl.regdst = 1'b1;
                w_ctl.wsrc   = (w_nstate == S_SH_WB) ? 4'd3 : 4'd0;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                w_ctl.srca = 1'b1;
                w_ctl.srcb = 4'd2;
                w_ctl.alu  = ALU_ADD;
            end
            S_WB_I: w_ctl.regw = 1'b1;
            S_JR: begin
                w_ctl.srca = 1'b1;
                w_ctl.alu  = ALU_PASSA;
                w_ctl.pcw  = 1'b1;
            end
            S_SH_LD: w_ctl.sh = 3'b001;
            S_SH_OP: w_ctl.sh = (FUNCT == FN_SRL) ? 3'b011 : 3'b010;
            S_MEM_RD: begin
                w_ctl.iord = 1'b1;
                w_ctl.memr = 1'b1;
            end
            S_MEM_WB: begin
                w_ctl.memtoreg = 1'b1;
                w_ctl.regw     = 1'b1;
            end
            S_MEM_WR: begin
                w_ctl.iord = 1'b1;
                w_ctl.memw = 1'b1;
            end
            // Zero is only valid during the BRANCH subtract, so PCwrite is gated with it live
            S_BRANCH: begin
                w_ctl.srca    = 1'b1;
                w_ctl.alu     = ALU_SUB;
                w_ctl.pcsrc   = 4'd1;
                w_ctl.pc_cond = 1'b1;
                w_ctl.bne     = (OPCODE == OP_BNE);
            end
            S_JUMP: begin
                w_ctl.pcsrc = 4'd2;
                w_ctl.pcw   = 1'b1;
            end
            S_EXC: begin
                w_ctl.epcw = 1'b1;
                w_ctl.srcb = 4'd1;
                w_ctl.alu  = ALU_SUB;
                w_ctl.exc  = w_nexc;
            end
            S_EXC_RD: begin
                w_ctl.iord = 1'b1;
                w_ctl.memr = 1'b1;
                w_ctl.exc  = w_nexc;
            end
            S_EXC_JMP: begin
                w_ctl.pcsrc = 4'd4;
                w_ctl.pcw   = 1'b1;
                w_ctl.exc   = w_nexc;
            end
            default: w_ctl = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_exc   <= '0;
            r_run   <= 1'b0;
            r_ctl   <= '0;
        end else begin
            r_state <= w_nstate;
            r_wait  <= w_nwait;
            r_exc   <= w_nexc;
            r_run   <= 1'b1;
            r_ctl   <= w_ctl;
        end
    end

    assign PCwrite      = r_ctl.pcw | (r_ctl.pc_cond & (Zero ^ r_ctl.bne));
    assign MemWrite     = r_ctl.memw;
    assign MemRead      = r_ctl.memr;
    assign IRWrite      = r_ctl.irw;
    assign RegWrite     = r_ctl.regw;
    assign MemToReg     = r_ctl.memtoreg;
    assign RegDest      = r_ctl.regdst;
    assign AluSrcA      = r_ctl.srca;
    assign EPCWrite     = r_ctl.epcw;
    assign IorD         = r_ctl.iord;
    assign AluSrcB      = r_ctl.srcb;
    assign PCSource     = r_ctl.pcsrc;
    assign WriteSrc     = r_ctl.wsrc;
    assign Exception    = r_ctl.exc;
    assign ShiftControl = r_ctl.sh;
    assign ALUControl   = r_ctl.alu;
    assign state_o      = r_state;
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected state/control records are queued with each
// instruction and popped one per clock, sampled 1ns after the rising edge.
module tb_control_unit;
    localparam int MW = 2;

    localparam logic [9:0] F_PCW = 10'h200, F_MEMW = 10'h100, F_MEMR = 10'h080, F_REGW = 10'h040;
    localparam logic [9:0] F_IRW = 10'h020, F_EPCW = 10'h010, F_IORD = 10'h008, F_REGDST = 10'h004;
    localparam logic [9:0] F_MTR = 10'h002, F_SRCA = 10'h001;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OPCODE, FUNCT;
    logic       Overflow, Zero;
    logic       PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg, RegDest, AluSrcA;
    logic       EPCWrite, IorD;
    logic [3:0] AluSrcB, PCSource, WriteSrc, Exception;
    logic [2:0] ShiftControl, ALUControl;
    logic [4:0] state_o;

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] q[$];

    control_unit #(.MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Overflow(Overflow), .Zero(Zero),
        .PCwrite(PCwrite), .MemWrite(MemWrite), .MemRead(MemRead), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .RegDest(RegDest), .AluSrcA(AluSrcA),
        .EPCWrite(EPCWrite), .IorD(IorD), .AluSrcB(AluSrcB), .PCSource(PCSource),
        .WriteSrc(WriteSrc), .Exception(Exception), .ShiftControl(ShiftControl),
        .ALUControl(ALUControl), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rec(input logic [4:0] st, input logic [9:0] fl,
                                        input logic [3:0] srcb, input logic [3:0] pcsrc,
                                        input logic [3:0] wsrc, input logic [3:0] exc,
                                        input logic [2:0] sh, input logic [2:0] alu);
        return {27'd0, st, fl, srcb, pcsrc, wsrc, exc, sh, alu};
    endfunction

    function automatic logic [63:0] observed();
        return rec(state_o, {PCwrite, MemWrite, MemRead, RegWrite, IRWrite, EPCWrite, IorD,
                             RegDest, MemToReg, AluSrcA},
                   AluSrcB, PCSource, WriteSrc, Exception, ShiftControl, ALUControl);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] st, input logic [9:0] fl, input logic [3:0] srcb,
                        input logic [3:0] pcsrc, input logic [3:0] wsrc, input logic [3:0] exc,
                        input logic [2:0] sh, input logic [2:0] alu);
        q.push_back(rec(st, fl, srcb, pcsrc, wsrc, exc, sh, alu));
    endtask

    task automatic push_fd();
        for (int c = 0; c < MW; c++) push(5'd0, F_MEMR, 4'd1, 4'd0, 4'd0, 4'd0, 3'd0, 3'd1);
        push(5'd0, F_MEMR | F_PCW | F_IRW, 4'd1, 4'd0, 4'd0, 4'd0, 3'd0, 3'd1);
        push(5'd1, 10'd0, 4'd3, 4'd0, 4'd0, 4'd0, 3'd0, 3'd1);
    endtask

    task automatic push_exc(input logic [3:0] sel);
        push(5'd16, F_EPCW, 4'd1, 4'd0, 4'd0, sel, 3'd0, 3'd2);
        for (int c = 0; c <= MW; c++) push(5'd17, F_IORD | F_MEMR, 4'd0, 4'd0, 4'd0, sel, 3'd0, 3'd0);
        push(5'd18, F_PCW, 4'd0, 4'd4, 4'd0, sel, 3'd0, 3'd0);
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic ovf, input logic z);
        int i;
        OPCODE = op;
        FUNCT = fn;
        Overflow = ovf;
        Zero = z;
        i = 0;
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("%s c%0d", tag, i), observed(), q.pop_front());
            i++;
        end
    endtask

    task automatic push_rw(input logic [2:0] alu);
        push(5'd2, F_SRCA, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, alu);
        push(5'd3, F_REGW | F_REGDST, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0);
    endtask

    task automatic push_lw();
        push(5'd10, F_SRCA, 4'd2, 4'd0, 4'd0, 4'd0, 3'd0, 3'd1);
        for (int c = 0; c <= MW; c++) push(5'd11, F_IORD | F_MEMR, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0);
        push(5'd12, F_MTR | F_REGW, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0);
    endtask

    initial begin
        reset = 1'b0;
        OPCODE = '0;
        FUNCT = '0;
        Overflow = 1'b0;
        Zero = 1'b0;
        #1;
        check_eq("reset_state", observed(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_held", observed(), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        push_fd(); push_rw(3'd1);                       run("add", 6'h00, 6'h20, 1'b0, 1'b0);
        push_fd(); push_rw(3'd2);                       run("sub", 6'h00, 6'h22, 1'b0, 1'b0);
        push_fd(); push_rw(3'd3);                       run("and_ovf", 6'h00, 6'h24, 1'b1, 1'b0);
        push_fd(); push_lw();                           run("lw", 6'h23, 6'h00, 1'b0, 1'b0);
        push_fd(); push(5'd10, F_SRCA, 4'd2, 4'd0, 4'd0, 4'd0, 3'd0, 3'd1);
        push(5'd13, F_IORD | F_MEMW, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0);
        run("sw", 6'h2b, 6'h00, 1'b0, 1'b0);
        push_fd(); push(5'd14, F_SRCA | F_PCW, 4'd0, 4'd1, 4'd0, 4'd0, 3'd0, 3'd2);
        run("beq_z1", 6'h04, 6'h00, 1'b0, 1'b1);
        push_fd(); push(5'd14, F_SRCA, 4'd0, 4'd1, 4'd0, 4'd0, 3'd0, 3'd2);
        run("bne_z1", 6'h05, 6'h00, 1'b0, 1'b1);
        push_fd(); push(5'd14, F_SRCA, 4'd0, 4'd1, 4'd0, 4'd0, 3'd0, 3'd2);
        run("beq_z0", 6'h04, 6'h00, 1'b0, 1'b0);
        push_fd(); push(5'd14, F_SRCA | F_PCW, 4'd0, 4'd1, 4'd0, 4'd0, 3'd0, 3'd2);
        run("bne_z0", 6'h05, 6'h00, 1'b0, 1'b0);
        push_fd(); push(5'd2, F_SRCA, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd1); push_exc(4'd2);
        run("add_ovf", 6'h00, 6'h20, 1'b1, 1'b0);
        push_fd(); push(5'd4, F_SRCA, 4'd2, 4'd0, 4'd0, 4'd0, 3'd0, 3'd1);
        push(5'd5, F_REGW, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0);
        run("addi", 6'h08, 6'h00, 1'b0, 1'b0);
        push_fd(); push(5'd4, F_SRCA, 4'd2, 4'd0, 4'd0, 4'd0, 3'd0, 3'd1); push_exc(4'd2);
        run("addi_ovf", 6'h08, 6'h00, 1'b1, 1'b0);
        push_fd(); push_exc(4'd1);                      run("bad_op", 6'h3f, 6'h00, 1'b0, 1'b0);
        push_fd(); push_exc(4'd1);                      run("bad_fn", 6'h00, 6'h3f, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            push_fd();
            push(5'd7, 10'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'b001, 3'd0);
            push(5'd8, 10'd0, 4'd0, 4'd0, 4'd0, 4'd0, (k == 0) ? 3'b010 : 3'b011, 3'd0);
            push(5'd9, F_REGW | F_REGDST, 4'd0, 4'd0, 4'd3, 4'd0, 3'b000, 3'd0);
            run((k == 0) ? "sll" : "srl", 6'h00, (k == 0) ? 6'h00 : 6'h02, 1'b0, 1'b0);
        end
        push_fd(); push(5'd6, F_PCW | F_SRCA, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0);
        run("jr", 6'h00, 6'h08, 1'b0, 1'b0);
        push_fd(); push(5'd15, F_PCW, 4'd0, 4'd2, 4'd0, 4'd0, 3'd0, 3'd0);
        run("j", 6'h02, 6'h00, 1'b0, 1'b0);

        push_fd(); push(5'd10, F_SRCA, 4'd2, 4'd0, 4'd0, 4'd0, 3'd0, 3'd1);
        push(5'd11, F_IORD | F_MEMR, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0);
        run("lw_part", 6'h23, 6'h00, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_eq("rst_mid_memrd", observed(), 64'd0);
        @(posedge clk);
        #1;
        check_eq("rst_mid_hold", observed(), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        push_fd(); push_rw(3'd1);                       run("add_after_rst", 6'h00, 6'h20, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
